gate_tester: RTL and testbench

Automatic truth-table reader for an external 2-input logic gate in the FPGA block library. It drives the gate's `a`/`b` inputs through all four combinations and samples the gate output `y` after a programmable settle time. It then reports the 4-bit truth table and a decoded function code: AND, NAND, OR, NOR, XOR, XNOR or constant. It sits on the stimulus/readback side of any gate block in the library and serves as the board-level self-test harness for those gates.

---
 rtl/gate_tester_pkg.sv | 42 ++++
 rtl/gate_tester_sync2.sv | 23 ++
 rtl/gate_tester.sv | 139 +++++++++++++
 tb/tb_gate_tester.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/gate_tester_pkg.sv
// Shared constants for gate_tester: FSM state codes, function codes and the
// truth patterns recognised by the decoder.
package gate_tester_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] FN_UNKNOWN = 3'd0;
  localparam logic [2:0] FN_AND     = 3'd1;
  localparam logic [2:0] FN_NAND    = 3'd2;
  localparam logic [2:0] FN_OR      = 3'd3;
  localparam logic [2:0] FN_NOR     = 3'd4;
  localparam logic [2:0] FN_XOR     = 3'd5;
  localparam logic [2:0] FN_XNOR    = 3'd6;
  localparam logic [2:0] FN_CONST   = 3'd7;

  // Bit {a,b} of each pattern is the gate output for that input pair.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  function automatic logic [2:0] decode(input logic [3:0] t);
    logic [2:0] f;
    f = FN_UNKNOWN;
    case (t)
      TT_AND:           f = FN_AND;
      TT_NAND:          f = FN_NAND;
      TT_OR:            f = FN_OR;
      TT_NOR:           f = FN_NOR;
      TT_XOR:           f = FN_XOR;
      TT_XNOR:          f = FN_XNOR;
      4'b0000, 4'b1111: f = FN_CONST;
      default:          f = FN_UNKNOWN;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/gate_tester_sync2.sv
// Generic two-flop synchronizer, synchronous active-low reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, q_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q_q    <= 1'b0;
    end else begin
      meta_q <= d;
      q_q    <= meta_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/gate_tester.sv
// Steps an external 2-input gate through 00,01,10,11 and decodes its truth table.
// Optional macro GATE_TESTER_DOUBLE_SAMPLE_EN adds a second sample per combination.
module gate_tester
  import gate_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] func,
  output logic       unstable
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES);

  logic          y_s;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    ab_q, ab_d;
  logic [3:0]    shadow_q, shadow_d;
  logic [3:0]    truth_q, truth_d;
  logic [2:0]    func_q, func_d;
`ifdef GATE_TESTER_DOUBLE_SAMPLE_EN
  logic          samp1_q, samp1_d;
  logic          flag_q, flag_d;
  logic          unst_q, unst_d;
`endif

  sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(y), .q(y_s));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ab_d     = ab_q;
    shadow_d = shadow_q;
    truth_d  = truth_q;
    func_d   = func_q;
`ifdef GATE_TESTER_DOUBLE_SAMPLE_EN
    samp1_d  = samp1_q;
    flag_d   = flag_q;
    unst_d   = unst_q;
`endif
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_WAIT;
        idx_d    = 2'd0;
        ab_d     = 2'b00;
        cnt_d    = CNT_INIT;
        shadow_d = 4'b0000;
`ifdef GATE_TESTER_DOUBLE_SAMPLE_EN
        flag_d   = 1'b0;
`endif
      end
      ST_WAIT: if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
`ifdef GATE_TESTER_DOUBLE_SAMPLE_EN
        if (cnt_q == CW'(1)) samp1_d = y_s;
`endif
      end else begin
        shadow_d[idx_q] = y_s;
`ifdef GATE_TESTER_DOUBLE_SAMPLE_EN
        if (y_s != samp1_q) flag_d = 1'b1;
`endif
        // {a,b} advances on the same edge that samples the current pair
        if (idx_q == 2'd3) begin
          state_d = ST_DONE;
          ab_d    = 2'b00;
        end else begin
          idx_d = idx_q + 2'd1;
          ab_d  = idx_q + 2'd1;
          cnt_d = CNT_INIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        truth_d = shadow_q;
        func_d  = decode(shadow_q);
`ifdef GATE_TESTER_DOUBLE_SAMPLE_EN
        unst_d  = flag_q;
        if (flag_q) func_d = FN_UNKNOWN;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      ab_q     <= 2'b00;
      shadow_q <= 4'b0000;
      truth_q  <= 4'b0000;
      func_q   <= FN_UNKNOWN;
`ifdef GATE_TESTER_DOUBLE_SAMPLE_EN
      samp1_q  <= 1'b0;
      flag_q   <= 1'b0;
      unst_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ab_q     <= ab_d;
      shadow_q <= shadow_d;
      truth_q  <= truth_d;
      func_q   <= func_d;
`ifdef GATE_TESTER_DOUBLE_SAMPLE_EN
      samp1_q  <= samp1_d;
      flag_q   <= flag_d;
      unst_q   <= unst_d;
`endif
    end
  end

  assign a     = ab_q[1];
  assign b     = ab_q[0];
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign truth = truth_q;
  assign func  = func_q;
`ifdef GATE_TESTER_DOUBLE_SAMPLE_EN
  assign unstable = unst_q;
`else
  assign unstable = 1'b0;
`endif

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: the external gate is a 4-entry lookup table driven by the bench.
module tb_gate_tester;

  localparam int S   = 4;
  localparam int LAT = 4 * (S + 1) + 1;

`ifdef GATE_TESTER_DOUBLE_SAMPLE_EN
  localparam bit DSE = 1'b1;
`else
  localparam bit DSE = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       a, b, y, busy, done, unstable;
  logic [3:0] truth;
  logic [2:0] func;
  logic [3:0] gate_tt = 4'b0000;
  logic       glitch = 1'b0;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  assign y = gate_tt[{a, b}] ^ glitch;

  gate_tester #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .truth(truth), .func(func), .unstable(unstable)
  );

  function automatic logic [2:0] ref_func(input logic [3:0] t);
    case (t)
      4'b1000:          return 3'd1;
      4'b0111:          return 3'd2;
      4'b1110:          return 3'd3;
      4'b0001:          return 3'd4;
      4'b0110:          return 3'd5;
      4'b1001:          return 3'd6;
      4'b0000, 4'b1111: return 3'd7;
      default:          return 3'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run(input logic [3:0] tt, input bit extra_starts, input bit glitch_en);
    int ndone, dat, nbusy;
    bit abok;
    logic [1:0] exp_ab;
    logic [3:0] exp_t;
    gate_tt = tt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; dat = 0; nbusy = 0; abok = 1'b1;
    for (int n = 1; n <= LAT; n++) begin
      if (busy) nbusy++;
      if (done) begin ndone++; dat = n; end
      exp_ab = (n <= 4 * (S + 1)) ? 2'((n - 1) / (S + 1)) : 2'b00;
      if ({a, b} !== exp_ab) abok = 1'b0;
      if (extra_starts) start = (n == 3 || n == 20 || n == 21);
      if (glitch_en) begin
        if (n == 3 * S + 1) glitch = 1'b1;
        if (n == 3 * (S + 1) + 1) glitch = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_t = glitch_en ? (tt ^ 4'b0100) : tt;
    chk("done_count", ndone, 1);
    chk("done_latency", dat, LAT);
    chk("busy_cycles", nbusy, LAT);
    chk("ab_sequence", abok, 1);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    chk("truth", truth, exp_t);
    chk("func", func, (glitch_en && DSE) ? 3'd0 : ref_func(exp_t));
    chk("unstable", unstable, glitch_en && DSE);
  endtask

  initial begin
    logic [3:0] rt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ab", {a, b}, 0);
    chk("rst_truth", truth, 0);
    chk("rst_func", func, 0);
    chk("rst_unstable", unstable, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(4'b0111, 1'b0, 1'b0);
    run(4'b0110, 1'b0, 1'b0);
    run(4'b1001, 1'b0, 1'b0);
    run(4'b1111, 1'b0, 1'b0);
    run(4'b1100, 1'b0, 1'b0);
    run(4'b1000, 1'b1, 1'b0);
    run(4'b1110, 1'b0, 1'b0);
    run(4'b0001, 1'b0, 1'b0);
    run(4'b0000, 1'b0, 1'b0);
    run(4'b0111, 1'b0, 1'b0);

    // abort a run with reset at cycle 10, then restart in the first cycle after release
    gate_tt = 4'b0110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ab", {a, b}, 0);
    chk("abort_truth", truth, 0);
    chk("abort_func", func, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    run(4'b0110, 1'b0, 1'b0);

    run(4'b0111, 1'b0, 1'b1);
    run(4'b0111, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      rt = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (k > 0) chk("hold_truth", truth, gate_tt);
      run(rt, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
